sum_deserializer: RTL and testbench

Serial-in, parallel-out collector for the serial adder datapath. Receives the LSB-first sum bitstream from the Mealy adder FSM, together with the final carry. It assembles an N-bit result and presents it with a valid/ready handshake to the downstream consumer. It is the receiving end of the right-shifting operand registers that feed the adder.

---
 rtl/sum_deserializer.sv | 131 +++++++++++++
 tb/tb_sum_deserializer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sum_deserializer.sv
// Serial-in/parallel-out collector for the serial adder: gathers an LSB-first
// sum stream plus final carry into an N-bit word behind a valid/ready handshake.
// Optional sticky abort flag output: define SUM_DESER_ABORT_FLAG_EN.
module sum_deserializer #(
  parameter int N = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_start,
  input  logic         i_bit_en,
  input  logic         i_sum_bit,
  input  logic         i_cout,
  input  logic         i_ready,
  output logic [N-1:0] o_sum,
  output logic         o_cout,
  output logic         o_valid,
  output logic         o_busy
`ifdef SUM_DESER_ABORT_FLAG_EN
  ,
  output logic         o_abort
`endif
);

  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  shreg_q, shreg_d;
  logic [N-1:0]  sum_q, sum_d;
  logic          cout_q, cout_d;
  logic          valid_q, valid_d;
  logic          busy_q, busy_d;
  logic          abort_q, abort_d;
  logic [N-1:0]  shifted;

  assign shifted = {i_sum_bit, shreg_q[N-1:1]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    valid_d = valid_q;
    abort_d = abort_q;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d = COLLECT;
          cnt_d   = '0;
          shreg_d = '0;
        end
      end
      COLLECT: begin
        if (i_start) begin
          // Restart wins over any bit presented in the same cycle.
          cnt_d   = '0;
          shreg_d = '0;
          abort_d = 1'b1;
        end else if (i_bit_en) begin
          shreg_d = shifted;
          if (cnt_q == CW'(N-1)) begin
            sum_d   = shifted;
            cout_d  = i_cout;
            valid_d = 1'b1;
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DONE: begin
        // A start without ready is dropped; start with ready skips IDLE.
        if (i_ready) begin
          valid_d = 1'b0;
          abort_d = 1'b0;
          if (i_start) begin
            state_d = COLLECT;
            cnt_d   = '0;
            shreg_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == COLLECT);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      abort_q <= abort_d;
    end
  end

  assign o_sum   = sum_q;
  assign o_cout  = cout_q;
  assign o_valid = valid_q;
  assign o_busy  = busy_q;
`ifdef SUM_DESER_ABORT_FLAG_EN
  assign o_abort = abort_q;
`else
  logic unused_abort;
  assign unused_abort = abort_q;
`endif

endmodule

// File: tb/tb_sum_deserializer.sv
// Directed bench for sum_deserializer (N=8): reset, basic, gapped, abort,
// back-to-back and async reset scenarios with hand-computed results.
module tb_sum_deserializer;
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start, bit_en, sum_bit, cout, ready;
  logic [N-1:0] o_sum;
  logic         o_cout, o_valid, o_busy;
`ifdef SUM_DESER_ABORT_FLAG_EN
  logic         o_abort;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sum_deserializer #(.N(N)) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_start   (start),
    .i_bit_en  (bit_en),
    .i_sum_bit (sum_bit),
    .i_cout    (cout),
    .i_ready   (ready),
    .o_sum     (o_sum),
    .o_cout    (o_cout),
    .o_valid   (o_valid),
    .o_busy    (o_busy)
`ifdef SUM_DESER_ABORT_FLAG_EN
    ,
    .o_abort   (o_abort)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic drive_bit(input logic b, input logic c);
    bit_en  = 1'b1;
    sum_bit = b;
    cout    = c;
    tick();
    bit_en  = 1'b0;
    sum_bit = 1'b0;
    cout    = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 0; bit_en = 0; sum_bit = 0; cout = 0; ready = 0;
    #12;
    checks++;
    if (o_sum !== 8'h00 || o_cout !== 1'b0 || o_valid !== 1'b0 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset: sum=%h cout=%b valid=%b busy=%b expected 00 0 0 0",
               o_sum, o_cout, o_valid, o_busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [7:0] pat;
    pat = 8'h5A;
    pulse_start();
    checks++;
    if (o_busy !== 1'b1 || o_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_busy: busy=%b valid=%b expected 1 0", o_busy, o_valid);
    end
    for (int i = 0; i < N; i++) begin
      drive_bit(pat[i], (i == N-1));
      if (i == N-2) begin
        checks++;
        if (o_valid !== 1'b0) begin
          errors++;
          $display("FAIL basic_early: valid=%b after 7 bits expected 0", o_valid);
        end
      end
    end
    checks++;
    if (o_valid !== 1'b1 || o_sum !== 8'h5A || o_cout !== 1'b1 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_word: valid=%b sum=%h cout=%b busy=%b expected 1 5a 1 0",
               o_valid, o_sum, o_cout, o_busy);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (o_valid !== 1'b1 || o_sum !== 8'h5A || o_cout !== 1'b1) begin
        errors++;
        $display("FAIL basic_hold%0d: valid=%b sum=%h cout=%b expected 1 5a 1",
                 i, o_valid, o_sum, o_cout);
      end
    end
    ready = 1'b1;
    tick();
    ready = 1'b0;
    checks++;
    if (o_valid !== 1'b0 || o_busy !== 1'b0 || o_sum !== 8'h5A) begin
      errors++;
      $display("FAIL basic_accept: valid=%b busy=%b sum=%h expected 0 0 5a",
               o_valid, o_busy, o_sum);
    end
  endtask

  task automatic test_gapped();
    logic [7:0] pat;
    int k;
    pat = 8'h5A;
    k = 0;
    pulse_start();
    for (int c = 0; c < 2*N; c++) begin
      if (c % 2 == 0) begin
        bit_en = 1'b1; sum_bit = pat[k]; cout = 1'b0; k++;
      end else begin
        bit_en = 1'b0; sum_bit = ~pat[k-1]; cout = 1'b1;
      end
      tick();
      if (c == 2*N-3) begin
        checks++;
        if (o_valid !== 1'b0 || o_busy !== 1'b1) begin
          errors++;
          $display("FAIL gap_early: valid=%b busy=%b expected 0 1", o_valid, o_busy);
        end
      end
    end
    bit_en = 1'b0; sum_bit = 1'b0; cout = 1'b0;
    checks++;
    if (o_valid !== 1'b1 || o_sum !== 8'h5A || o_cout !== 1'b0) begin
      errors++;
      $display("FAIL gap_word: valid=%b sum=%h cout=%b expected 1 5a 0",
               o_valid, o_sum, o_cout);
    end
    ready = 1'b1;
    tick();
    ready = 1'b0;
  endtask

  task automatic test_abort();
    pulse_start();
    for (int i = 0; i < 3; i++) drive_bit(1'b1, 1'b1);
    start = 1'b1; bit_en = 1'b1; sum_bit = 1'b1;
    tick();
    start = 1'b0; bit_en = 1'b0; sum_bit = 1'b0;
    checks++;
    if (o_busy !== 1'b1 || o_valid !== 1'b0 || o_sum !== 8'h5A || o_cout !== 1'b0) begin
      errors++;
      $display("FAIL abort_restart: busy=%b valid=%b sum=%h cout=%b expected 1 0 5a 0",
               o_busy, o_valid, o_sum, o_cout);
    end
`ifdef SUM_DESER_ABORT_FLAG_EN
    checks++;
    if (o_abort !== 1'b1) begin
      errors++;
      $display("FAIL abort_flag_set: abort=%b expected 1", o_abort);
    end
`endif
    for (int i = 0; i < N; i++) begin
      drive_bit(1'b1, 1'b0);
      if (i == N-2) begin
        checks++;
        if (o_valid !== 1'b0) begin
          errors++;
          $display("FAIL abort_early: valid=%b after 7 bits expected 0", o_valid);
        end
      end
    end
    checks++;
    if (o_valid !== 1'b1 || o_sum !== 8'hFF || o_cout !== 1'b0) begin
      errors++;
      $display("FAIL abort_word: valid=%b sum=%h cout=%b expected 1 ff 0",
               o_valid, o_sum, o_cout);
    end
    // Start without ready in DONE must be lost.
    pulse_start();
    checks++;
    if (o_valid !== 1'b1 || o_busy !== 1'b0 || o_sum !== 8'hFF) begin
      errors++;
      $display("FAIL done_start_ignored: valid=%b busy=%b sum=%h expected 1 0 ff",
               o_valid, o_busy, o_sum);
    end
`ifdef SUM_DESER_ABORT_FLAG_EN
    checks++;
    if (o_abort !== 1'b1) begin
      errors++;
      $display("FAIL abort_flag_hold: abort=%b expected 1", o_abort);
    end
`endif
  endtask

  task automatic test_back_to_back();
    logic [7:0] pat;
    int low;
    pat = 8'h01;
    low = 0;
    start = 1'b1; ready = 1'b1;
    tick();
    start = 1'b0; ready = 1'b0;
    if (o_valid === 1'b0) low++;
    checks++;
    if (o_valid !== 1'b0 || o_busy !== 1'b1 || o_sum !== 8'hFF) begin
      errors++;
      $display("FAIL b2b_accept: valid=%b busy=%b sum=%h expected 0 1 ff",
               o_valid, o_busy, o_sum);
    end
`ifdef SUM_DESER_ABORT_FLAG_EN
    checks++;
    if (o_abort !== 1'b0) begin
      errors++;
      $display("FAIL abort_flag_clear: abort=%b expected 0", o_abort);
    end
`endif
    for (int i = 0; i < N; i++) begin
      drive_bit(pat[i], 1'b0);
      if (o_valid === 1'b0) low++;
    end
    checks++;
    if (low !== N) begin
      errors++;
      $display("FAIL b2b_gap: valid low %0d cycles expected %0d", low, N);
    end
    checks++;
    if (o_valid !== 1'b1 || o_sum !== 8'h01 || o_cout !== 1'b0) begin
      errors++;
      $display("FAIL b2b_word: valid=%b sum=%h cout=%b expected 1 01 0",
               o_valid, o_sum, o_cout);
    end
    ready = 1'b1;
    tick();
    ready = 1'b0;
  endtask

  task automatic test_async_reset();
    logic [7:0] pat;
    pat = 8'hC3;
    pulse_start();
    for (int i = 0; i < 4; i++) drive_bit(1'b1, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (o_sum !== 8'h00 || o_cout !== 1'b0 || o_valid !== 1'b0 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: sum=%h cout=%b valid=%b busy=%b expected 00 0 0 0",
               o_sum, o_cout, o_valid, o_busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    // Bits without a start are ignored in IDLE.
    drive_bit(1'b1, 1'b1);
    drive_bit(1'b1, 1'b1);
    checks++;
    if (o_busy !== 1'b0 || o_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_ignore: busy=%b valid=%b expected 0 0", o_busy, o_valid);
    end
    pulse_start();
    for (int i = 0; i < N; i++) drive_bit(pat[i], (i == N-1));
    checks++;
    if (o_valid !== 1'b1 || o_sum !== 8'hC3 || o_cout !== 1'b1) begin
      errors++;
      $display("FAIL reset_fresh_word: valid=%b sum=%h cout=%b expected 1 c3 1",
               o_valid, o_sum, o_cout);
    end
    ready = 1'b1;
    tick();
    ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gapped();
    test_abort();
    test_back_to_back();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
